imem_responder: RTL and testbench

IMEM_RESPONDER -- requirements
Module: imem_responder

---
 rtl/imem_responder_pkg.sv | 37 +++
 rtl/resp_fifo2.sv | 69 ++++++
 rtl/imem_responder.sv | 120 ++++++++++++
 tb/tb_imem_responder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/imem_responder_pkg.sv
// -----------------------------------------------------------------------------
// imem_responder_pkg
// Shared processor constants for the RV32I fetch path: the canonical NOP,
// base opcodes, the instruction-memory word-address width helper and the
// response payload carried from the instruction memory to the core.
// -----------------------------------------------------------------------------
package imem_responder_pkg;

    localparam int unsigned XLEN        = 32;
    localparam int unsigned INSTR_BYTES = 4;

    // addi x0, x0, 0 -- returned in place of any faulting fetch
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // RV32I base opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    // Width of a word index into a memory of depth_words 32-bit words.
    function automatic int unsigned word_addr_w(input int unsigned depth_words);
        return (depth_words > 1) ? $clog2(depth_words) : 1;
    endfunction

    // One fetch response: instruction word plus fault flag.
    typedef struct packed {
        logic [31:0] data;
        logic        err;
    } imem_rsp_t;

endpackage

// File: rtl/resp_fifo2.sv
// -----------------------------------------------------------------------------
// resp_fifo2
// Two-entry FIFO holding fetch responses (instruction word + error flag).
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   push_i, push_data_i     write strobe and payload
//   pop_i                   remove the head entry
//   full_o, empty_o         occupancy flags
//   head_o                  current head entry (valid when !empty_o)
// A simultaneous push and pop are both honoured, leaving occupancy unchanged.
// -----------------------------------------------------------------------------
module resp_fifo2
    import imem_responder_pkg::*;
(
    input  logic      clk,
    input  logic      reset_n,
    input  logic      push_i,
    input  imem_rsp_t push_data_i,
    input  logic      pop_i,
    output logic      full_o,
    output logic      empty_o,
    output imem_rsp_t head_o
);

    imem_rsp_t  entry_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;
    logic       do_push, do_pop;

    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign head_o  = entry_q[rd_ptr_q];

    // A push into a full FIFO is only legal when the head leaves this cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ do_push;
        rd_ptr_d = rd_ptr_q ^ do_pop;
        count_d  = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_entry
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    entry_q[gi] <= '0;
                end else if (do_push && (wr_ptr_q == 1'(gi))) begin
                    entry_q[gi] <= push_data_i;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/imem_responder.sv
// -----------------------------------------------------------------------------
// imem_responder
// Instruction memory with a valid/ready fetch port and a program-load port.
// Ports:
//   clk, reset_n                      clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr      fetch request (byte address)
//   rsp_valid/rsp_ready/rsp_data/rsp_err  in-order fetch response
//   ld_en/ld_addr/ld_data             program-load write port
// Faulting fetches (misaligned or beyond DEPTH_WORDS) return NOP with err set.
// Fetch latency is one cycle; up to two responses may be outstanding.
// -----------------------------------------------------------------------------
module imem_responder
    import imem_responder_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter              INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    input  logic        ld_en,
    input  logic [31:0] ld_addr,
    input  logic [31:0] ld_data
);

    localparam int unsigned AW = word_addr_w(DEPTH_WORDS);

    // Contents are left undefined unless a simulation environment preloads
    // INIT_FILE; in-system programming goes through the ld_* port.
    logic [31:0] mem [0:DEPTH_WORDS-1];

    logic        req_fire;
    logic        req_err;
    logic        ld_ok;
    logic [31:0] rd_data_q;
    logic        rd_err_q, rd_err_d;
    logic        inflight_q, inflight_d;

    imem_rsp_t   rd_rsp;
    imem_rsp_t   fifo_head;
    imem_rsp_t   rsp_head;
    logic        fifo_full, fifo_empty;
    logic        fifo_push, fifo_pop;
    logic        pop_fire;

    // Word index is compared on all 30 bits so high addresses never alias.
    assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:2] >= 30'(DEPTH_WORDS));
    assign ld_ok   = ld_en && (ld_addr[1:0] == 2'b00) && (ld_addr[31:2] < 30'(DEPTH_WORDS));

    // Occupancy + in-flight < 2, expressed on the FIFO flags: with the FIFO
    // not full, an in-flight read plus a non-empty FIFO makes two.
    assign req_ready = !ld_en && !fifo_full && !(inflight_q && !fifo_empty);
    assign req_fire  = req_valid && req_ready;

    // Synchronous-read RAM. Loads and fetches never share a cycle, so there
    // is no read/write collision to resolve.
    always_ff @(posedge clk) begin
        if (ld_ok) begin
            mem[ld_addr[AW+1:2]] <= ld_data;
        end
        if (req_fire) begin
            rd_data_q <= mem[req_addr[AW+1:2]];
        end
    end

    always_comb begin
        inflight_d = req_fire;
        rd_err_d   = req_fire ? req_err : rd_err_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            inflight_q <= 1'b0;
            rd_err_q   <= 1'b0;
        end else begin
            inflight_q <= inflight_d;
            rd_err_q   <= rd_err_d;
        end
    end

    assign rd_rsp.data = rd_err_q ? NOP_INSTR : rd_data_q;
    assign rd_rsp.err  = rd_err_q;

    // The freshly read word is presented directly when the FIFO is empty;
    // it only enters the FIFO if it is not consumed in that same cycle.
    always_comb begin
        rsp_head = '0;
        if (!fifo_empty) begin
            rsp_head = fifo_head;
        end else if (inflight_q) begin
            rsp_head = rd_rsp;
        end
    end

    assign rsp_valid = !fifo_empty || inflight_q;
    assign rsp_data  = rsp_head.data;
    assign rsp_err   = rsp_head.err;

    assign pop_fire  = rsp_valid && rsp_ready;
    assign fifo_pop  = pop_fire && !fifo_empty;
    assign fifo_push = inflight_q && !(fifo_empty && rsp_ready);

    resp_fifo2 u_resp_fifo2 (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (fifo_push),
        .push_data_i(rd_rsp),
        .pop_i      (fifo_pop),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .head_o     (fifo_head)
    );

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_err;
    logic        ld_en;
    logic [31:0] ld_addr;
    logic [31:0] ld_data;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH_WORDS(256), .INIT_FILE("")) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .ld_en    (ld_en),
        .ld_addr  (ld_addr),
        .ld_data  (ld_data)
    );

    typedef struct {
        string       name;
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    vec_t vecs [9];

    function automatic logic [31:0] word_of(input int i);
        if (i == 0) return 32'h0050_0093;
        return 32'hA000_0000 | (i << 8) | i;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_data = d;
        @(negedge clk);
        ld_en   = 1'b0;
    endtask

    initial begin
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_addr  = '0;
        rsp_ready = 1'b1;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_data   = '0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset_rsp_data", rsp_data, 32'd0);
        check("reset_rsp_err", 32'(rsp_err), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);
        check("post_reset_req_ready", 32'(req_ready), 32'd1);
        check("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // ---- program load ----
        for (int i = 0; i < 16; i++) load(32'(4 * i), word_of(i));
        load(32'h0000_03FC, 32'h5555_AAAA);
        load(32'h0000_0009, 32'hDEAD_BEEF);   // misaligned: ignored
        load(32'h0000_0400, 32'hDEAD_BEEF);   // out of range: must not alias word 0
        @(negedge clk);
        ld_en = 1'b1; ld_addr = 32'h0000_0009; ld_data = 32'hDEAD_BEEF;
        #1 check("ld_en_blocks_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        ld_en = 1'b0;

        // ---- single-request vectors ----
        vecs[0] = '{"w0_addi",    32'h0000_0000, 32'h0050_0093, 1'b0};
        vecs[1] = '{"misalign2",  32'h0000_0002, NOP,           1'b1};
        vecs[2] = '{"w1_order",   32'h0000_0004, word_of(1),    1'b0};
        vecs[3] = '{"oor_depth",  32'h0000_0400, NOP,           1'b1};
        vecs[4] = '{"last_word",  32'h0000_03FC, 32'h5555_AAAA, 1'b0};
        vecs[5] = '{"no_wrap",    32'hFFFF_FFFC, NOP,           1'b1};
        vecs[6] = '{"w2_keep",    32'h0000_0008, word_of(2),    1'b0};
        vecs[7] = '{"misalign1",  32'h0000_0001, NOP,           1'b1};
        vecs[8] = '{"w0_noalias", 32'h0000_0000, 32'h0050_0093, 1'b0};

        rsp_ready = 1'b1;
        for (int v = 0; v < 9; v++) begin
            @(negedge clk);
            check({vecs[v].name, "_ready"}, 32'(req_ready), 32'd1);
            req_valid = 1'b1;
            req_addr  = vecs[v].addr;
            @(negedge clk);
            req_valid = 1'b0;
            check({vecs[v].name, "_valid"}, 32'(rsp_valid), 32'd1);
            check({vecs[v].name, "_data"}, rsp_data, vecs[v].data);
            check({vecs[v].name, "_err"}, 32'(rsp_err), 32'(vecs[v].err));
            $display("req addr=%h -> valid=%0d data=%h err=%0d", vecs[v].addr, rsp_valid, rsp_data, rsp_err);
            @(negedge clk);
            check({vecs[v].name, "_drained"}, 32'(rsp_valid), 32'd0);
        end

        // ---- backpressure: three requests, rsp_ready low ----
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0;
        check("bp_ready0", 32'(req_ready), 32'd1);
        @(negedge clk);
        check("bp_ready1", 32'(req_ready), 32'd1);
        check("bp_rsp_a", rsp_data, word_of(0));
        req_addr = 32'h4;
        @(negedge clk);
        check("bp_ready_falls", 32'(req_ready), 32'd0);
        req_addr = 32'h8;
        for (int k = 0; k < 3; k++) begin
            check("bp_hold_valid", 32'(rsp_valid), 32'd1);
            check("bp_hold_data", rsp_data, word_of(0));
            check("bp_hold_err", 32'(rsp_err), 32'd0);
            check("bp_hold_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1 check("bp_ready_after_pop_pending", 32'(req_ready), 32'd0);
        @(negedge clk);
        $display("drain: valid=%0d data=%h ready=%0d", rsp_valid, rsp_data, req_ready);
        check("bp_drain_b", rsp_data, word_of(1));
        check("bp_c_accepted_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("bp_c_valid", 32'(rsp_valid), 32'd1);
        check("bp_c_data", rsp_data, word_of(2));
        @(negedge clk);
        check("bp_empty", 32'(rsp_valid), 32'd0);

        // ---- streaming 0x0..0x3C ----
        rsp_ready = 1'b1;
        for (int i = 0; i <= 16; i++) begin
            @(negedge clk);
            if (i > 0) begin
                check("stream_valid", 32'(rsp_valid), 32'd1);
                check("stream_data", rsp_data, word_of(i - 1));
                $display("stream %0d: data=%h", i - 1, rsp_data);
            end
            if (i < 16) begin
                check("stream_ready", 32'(req_ready), 32'd1);
                req_valid = 1'b1;
                req_addr  = 32'(4 * i);
            end else begin
                req_valid = 1'b0;
            end
        end
        @(negedge clk);
        check("stream_done", 32'(rsp_valid), 32'd0);

        // ---- old data before load, new data after ----
        req_valid = 1'b1; req_addr = 32'hC;
        @(negedge clk);
        req_valid = 1'b0;
        ld_en = 1'b1; ld_addr = 32'hC; ld_data = 32'h1234_5678;
        check("raw_old_data", rsp_data, word_of(3));
        @(negedge clk);
        ld_en = 1'b0;
        req_valid = 1'b1; req_addr = 32'hC;
        @(negedge clk);
        req_valid = 1'b0;
        check("raw_new_data", rsp_data, 32'h1234_5678);
        $display("load-then-fetch: data=%h", rsp_data);

        // ---- reset with two queued responses ----
        rsp_ready = 1'b0;
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0;
        @(negedge clk);
        req_addr = 32'h4;
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_queued_valid", 32'(rsp_valid), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        check("rst_async_valid", 32'(rsp_valid), 32'd0);
        check("rst_async_data", rsp_data, 32'd0);
        check("rst_async_err", 32'(rsp_err), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_rel_ready", 32'(req_ready), 32'd1);
        check("rst_rel_valid", 32'(rsp_valid), 32'd0);
        rsp_ready = 1'b1;
        ld_en = 1'b1; ld_addr = 32'h0000_0400; ld_data = 32'h0;
        #1 check("rst_ld_en_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        ld_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rst_no_stale", 32'(rsp_valid), 32'd0);
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
